// File: rtl/operand_entry_pkg.sv
// Shared types and defaults for the operand entry path.
// Fixed state encodings are visible on the STATE output.
package operand_entry_pkg;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    SHOW   = 2'b10
  } state_t;

endpackage

// File: rtl/operand_entry_fsm_key_debouncer.sv
// Synchronises, debounces and edge-detects an active-low pushbutton.
// press is a single-cycle pulse on an accepted 1->0 level change.
module key_debouncer
  import operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic level,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;
  logic             level_prev;

  // Stability counter: accept the synced level only after it has differed long enough
  always_comb begin
    cnt_next   = cnt;
    level_next = level;
    if (sync2 == level) begin
      cnt_next = {CNT_W{1'b0}};
    end else if (cnt == CNT_LAST) begin
      cnt_next   = {CNT_W{1'b0}};
      level_next = sync2;
    end else begin
      cnt_next = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Synchroniser, debounce state and registered falling-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      cnt        <= {CNT_W{1'b0}};
      level      <= 1'b1;
      level_prev <= 1'b1;
      press      <= 1'b0;
    end else begin
      sync1      <= key;
      sync2      <= sync1;
      cnt        <= cnt_next;
      level      <= level_next;
      level_prev <= level;
      press      <= level_prev & ~level;
    end
  end

endmodule

// File: rtl/operand_entry_fsm.sv
// Operand entry sequencer: loads A then B from SW on debounced KEY1 presses
// and holds a registered, carry-preserving sum for the display stage.
module operand_entry_fsm
  import operand_entry_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             CLOCK_50,
  input  logic             KEY0,
  input  logic             KEY1,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   SUM,
  output logic [1:0]       STATE,
  output logic             SUM_VALID
);

  state_t state;
  state_t next_state;
  logic   key_level;
  logic   key_press;
  logic   pressed;
  logic   load_a;
  logic   load_b;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key1 (
    .clk  (CLOCK_50),
    .rst_n(KEY0),
    .key  (KEY1),
    .level(key_level),
    .press(key_press)
  );

  // The pulse can only follow a fall, so qualifying with the level is a cheap guard
  assign pressed = key_press & ~key_level;
  assign STATE   = state;

  // Next-state and load-enable decode
  always_comb begin
    next_state = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    case (state)
      LOAD_A: begin
        if (pressed) begin
          load_a     = 1'b1;
          next_state = LOAD_B;
        end else begin
          next_state = LOAD_A;
        end
      end
      LOAD_B: begin
        if (pressed) begin
          load_b     = 1'b1;
          next_state = SHOW;
        end else begin
          next_state = LOAD_B;
        end
      end
      SHOW: begin
        if (pressed) begin
          load_a     = 1'b1;
          next_state = LOAD_B;
        end else begin
          next_state = SHOW;
        end
      end
      default: begin
        next_state = LOAD_A;
      end
    endcase
  end

  // State, operand and sum registers
  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      state     <= LOAD_A;
      A         <= {WIDTH{1'b0}};
      B         <= {WIDTH{1'b0}};
      SUM       <= {(WIDTH+1){1'b0}};
      SUM_VALID <= 1'b0;
    end else begin
      state <= next_state;
      if (load_a) begin
        A         <= SW;
        SUM_VALID <= 1'b0;
      end
      if (load_b) begin
        B         <= SW;
        SUM       <= {1'b0, A} + {1'b0, SW};
        SUM_VALID <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_operand_entry_fsm.sv
// Scoreboard bench: presses push expected output snapshots with their due cycle;
// a negedge monitor pops one entry per observed output change.
module tb_operand_entry_fsm;

  logic       CLOCK_50 = 1'b0;
  logic       KEY0     = 1'b0;
  logic       KEY1     = 1'b1;
  logic [7:0] SW       = 8'h00;
  logic [7:0] A;
  logic [7:0] B;
  logic [8:0] SUM;
  logic [1:0] STATE;
  logic       SUM_VALID;

  typedef struct {
    logic [27:0] val;
    int          due;
  } exp_t;

  exp_t        q[$];
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          mon_en   = 1'b0;
  logic [27:0] prev;

  operand_entry_fsm #(
    .WIDTH(8),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .KEY0     (KEY0),
    .KEY1     (KEY1),
    .SW       (SW),
    .A        (A),
    .B        (B),
    .SUM      (SUM),
    .STATE    (STATE),
    .SUM_VALID(SUM_VALID)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  function automatic logic [27:0] expv(input logic [7:0] a, input logic [7:0] b,
                                       input logic [8:0] s, input logic v,
                                       input logic [1:0] st);
    return {a, b, s, v, st};
  endfunction

  function automatic logic [27:0] outs();
    return {A, B, SUM, SUM_VALID, STATE};
  endfunction

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every output change must match the oldest expected snapshot and its due cycle
  always @(negedge CLOCK_50) begin
    if (mon_en) begin
      logic [27:0] cur;
      exp_t        e;
      cur = outs();
      if (cur !== prev) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change actual=%h cycle=%0d", cur, cyc);
        end else begin
          e = q.pop_front();
          if (cur !== e.val || (e.due >= 0 && cyc != e.due)) begin
            failures++;
            $display("FAIL scoreboard actual=%h@%0d expected=%h@%0d", cur, cyc, e.val, e.due);
          end
        end
      end
      prev = cur;
    end
  end

  // Clean press: update due on the 8th rising edge counting the one that first samples KEY1 low
  task automatic press(input logic [7:0] sw, input logic [27:0] e, input int hold);
    @(negedge CLOCK_50);
    SW   = sw;
    KEY1 = 1'b0;
    q.push_back('{val: e, due: cyc + 8});
    repeat (hold) @(negedge CLOCK_50);
    KEY1 = 1'b1;
    SW   = 8'hA5;
    repeat (12) @(negedge CLOCK_50);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      @(negedge CLOCK_50);
      KEY1 = 1'($urandom_range(0, 1));
      SW   = 8'($urandom_range(0, 255));
      if (i % 4 == 3) check("reset_hold", outs(), expv(8'h00, 8'h00, 9'h000, 1'b0, 2'b00));
    end
    KEY1 = 1'b1;
    @(negedge CLOCK_50);
    KEY0 = 1'b1;
    repeat (10) @(negedge CLOCK_50);
    check("post_reset_idle", outs(), expv(8'h00, 8'h00, 9'h000, 1'b0, 2'b00));
    prev   = outs();
    mon_en = 1'b1;

    press(8'h3C, expv(8'h3C, 8'h00, 9'h000, 1'b0, 2'b01), 10);
    press(8'h05, expv(8'h3C, 8'h05, 9'h041, 1'b1, 2'b10), 10);
    press(8'h10, expv(8'h10, 8'h05, 9'h041, 1'b0, 2'b01), 10);
    press(8'h20, expv(8'h10, 8'h20, 9'h030, 1'b1, 2'b10), 10);
    press(8'hFF, expv(8'hFF, 8'h20, 9'h030, 1'b0, 2'b01), 10);
    press(8'h01, expv(8'hFF, 8'h01, 9'h100, 1'b1, 2'b10), 10);
    press(8'hFF, expv(8'hFF, 8'h01, 9'h100, 1'b0, 2'b01), 10);
    press(8'hFF, expv(8'hFF, 8'hFF, 9'h1FE, 1'b1, 2'b10), 10);

    // Bounce: low 2, high 1, low 3, then released
    @(negedge CLOCK_50);
    KEY1 = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    KEY1 = 1'b1;
    @(negedge CLOCK_50);
    KEY1 = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    KEY1 = 1'b1;
    repeat (20) @(negedge CLOCK_50);
    check("bounce_rejected", outs(), expv(8'hFF, 8'hFF, 9'h1FE, 1'b1, 2'b10));

    press(8'h7A, expv(8'h7A, 8'hFF, 9'h1FE, 1'b0, 2'b01), 50);

    q.push_back('{val: expv(8'h00, 8'h00, 9'h000, 1'b0, 2'b00), due: -1});
    @(posedge CLOCK_50);
    #1 KEY0 = 1'b0;
    @(posedge CLOCK_50);
    #1 KEY0 = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    check("after_reset_pulse", outs(), expv(8'h00, 8'h00, 9'h000, 1'b0, 2'b00));

    press(8'h11, expv(8'h11, 8'h00, 9'h000, 1'b0, 2'b01), 10);

    repeat (20) @(negedge CLOCK_50);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL pending_expectations actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
